// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with operand forwarding, load-use bubble insertion,
// branch flush and downstream hold.
module id_ex_stage #(
  parameter int DATA_LEN     = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int CTRL_LEN     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [DATA_LEN-1:0]     id_pc,
  input  logic [REG_ADDR_LEN-1:0] id_raddr1,
  input  logic [REG_ADDR_LEN-1:0] id_raddr2,
  input  logic                    id_rs1_used,
  input  logic                    id_rs2_used,
  input  logic [DATA_LEN-1:0]     id_rdata1,
  input  logic [DATA_LEN-1:0]     id_rdata2,
  input  logic [DATA_LEN-1:0]     id_imm,
  input  logic [REG_ADDR_LEN-1:0] id_waddr,
  input  logic                    id_we,
  input  logic                    id_is_load,
  input  logic [CTRL_LEN-1:0]     id_ctrl,
  input  logic                    exmem_we,
  input  logic [REG_ADDR_LEN-1:0] exmem_waddr,
  input  logic [DATA_LEN-1:0]     exmem_wdata,
  input  logic                    memwb_we,
  input  logic [REG_ADDR_LEN-1:0] memwb_waddr,
  input  logic [DATA_LEN-1:0]     memwb_wdata,
  input  logic                    flush,
  input  logic                    hold,
  output logic                    id_stall,
  output logic                    ex_valid,
  output logic [DATA_LEN-1:0]     ex_pc,
  output logic [DATA_LEN-1:0]     ex_op1,
  output logic [DATA_LEN-1:0]     ex_op2,
  output logic [DATA_LEN-1:0]     ex_imm,
  output logic [REG_ADDR_LEN-1:0] ex_waddr,
  output logic                    ex_we,
  output logic                    ex_is_load,
  output logic [CTRL_LEN-1:0]     ex_ctrl
);

  typedef struct packed {
    logic                    valid;
    logic [DATA_LEN-1:0]     pc;
    logic [DATA_LEN-1:0]     op1;
    logic [DATA_LEN-1:0]     op2;
    logic [DATA_LEN-1:0]     imm;
    logic [REG_ADDR_LEN-1:0] waddr;
    logic                    we;
    logic                    is_load;
    logic [CTRL_LEN-1:0]     ctrl;
  } ex_t;

  ex_t                 ex_q;
  ex_t                 ex_d;
  logic [DATA_LEN-1:0] fwd_op1;
  logic [DATA_LEN-1:0] fwd_op2;
  logic                exmem_hit1, exmem_hit2;
  logic                memwb_hit1, memwb_hit2;
  logic                ex_load_live;
  logic                load_use;

  // x0 is hardwired, so a producer targeting it never supplies a forwarded value
  assign exmem_hit1 = exmem_we && (exmem_waddr != '0) && (exmem_waddr == id_raddr1);
  assign exmem_hit2 = exmem_we && (exmem_waddr != '0) && (exmem_waddr == id_raddr2);
  assign memwb_hit1 = memwb_we && (memwb_waddr != '0) && (memwb_waddr == id_raddr1);
  assign memwb_hit2 = memwb_we && (memwb_waddr != '0) && (memwb_waddr == id_raddr2);

  always_comb begin
    fwd_op1 = id_rdata1;
    if (exmem_hit1)      fwd_op1 = exmem_wdata;
    else if (memwb_hit1) fwd_op1 = memwb_wdata;
  end

  always_comb begin
    fwd_op2 = id_rdata2;
    if (exmem_hit2)      fwd_op2 = exmem_wdata;
    else if (memwb_hit2) fwd_op2 = memwb_wdata;
  end

  assign ex_load_live = ex_q.valid && ex_q.is_load && ex_q.we && (ex_q.waddr != '0);
  assign load_use     = ex_load_live && id_valid &&
                        ((id_rs1_used && (id_raddr1 == ex_q.waddr)) ||
                         (id_rs2_used && (id_raddr2 == ex_q.waddr)));

  // A flush kills the ID instruction, so there is nothing left to stall for.
  assign id_stall = (load_use || hold) && !flush;

  always_comb begin
    ex_d         = '0;
    ex_d.valid   = id_valid;
    ex_d.pc      = id_pc;
    ex_d.op1     = fwd_op1;
    ex_d.op2     = fwd_op2;
    ex_d.imm     = id_imm;
    ex_d.waddr   = id_waddr;
    ex_d.we      = id_we && id_valid;
    ex_d.is_load = id_is_load && id_valid;
    ex_d.ctrl    = id_ctrl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (hold) begin
      ex_q <= ex_q;
    end else if (load_use) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_pc      = ex_q.pc;
  assign ex_op1     = ex_q.op1;
  assign ex_op2     = ex_q.op2;
  assign ex_imm     = ex_q.imm;
  assign ex_waddr   = ex_q.waddr;
  assign ex_we      = ex_q.we;
  assign ex_is_load = ex_q.is_load;
  assign ex_ctrl    = ex_q.ctrl;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID→EX pipeline boundary, directly downstream of the register file.
- Captures decoded instruction fields and the register-file read data (rdata1/rdata2) into the EX stage.
- Applies EX/MEM and MEM/WB result forwarding to source operands before capture.
- Detects load-use hazards, inserts bubbles and stalls upstream.
- Honours branch flush and downstream hold.

Parameters:
DATA_LEN, 32, operand/PC/immediate width
REG_ADDR_LEN, 5, register address width
CTRL_LEN, 16, opaque EX/MEM/WB control bundle width (passed through unmodified)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  ID slot holds a real instruction
id_pc  in  DATA_LEN  instruction PC
id_raddr1 / id_raddr2  in  REG_ADDR_LEN  source register addresses
id_rs1_used / id_rs2_used  in  1  instruction actually reads that source
id_rdata1 / id_rdata2  in  DATA_LEN  register file read data
id_imm  in  DATA_LEN  sign-extended immediate
id_waddr  in  REG_ADDR_LEN  destination register
id_we  in  1  instruction writes a register
id_is_load  in  1  instruction is a load
id_ctrl  in  CTRL_LEN  control bundle
exmem_we / exmem_waddr / exmem_wdata  in  1 / REG_ADDR_LEN / DATA_LEN  EX/MEM result (non-load)
memwb_we / memwb_waddr / memwb_wdata  in  1 / REG_ADDR_LEN / DATA_LEN  MEM/WB writeback result
flush  in  1  branch/jump taken in EX; kill the ID instruction
hold  in  1  downstream stall; freeze EX registers
id_stall  out  1  upstream (IF/ID, PC) must not advance
ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_waddr, ex_we, ex_is_load, ex_ctrl  out  registered EX-stage copies

Behaviour:
- Reset (rst=1 at edge): every registered output = 0. id_stall is combinational and is 0 while all ex_* are 0.
- Forwarding (combinational, per source n∈{1,2}), first match wins:
  1. exmem_we && exmem_waddr!=0 && exmem_waddr==id_raddrn → exmem_wdata
  2. memwb_we && memwb_waddr!=0 && memwb_waddr==id_raddrn → memwb_wdata
  3. otherwise → id_rdatan
  - Address 0 is never forwarded; the operand is whatever the register file returns.
  - MEM/WB forwarding is mandatory: the register file commits at the edge, so same-cycle reads see the old value.
- Load-use hazard: load_use = ex_valid && ex_is_load && ex_we && ex_waddr!=0 && id_valid && ((id_rs1_used && id_raddr1==ex_waddr) || (id_rs2_used && id_raddr2==ex_waddr)).
- id_stall = (load_use || hold) && !flush.
- Edge priority (exactly one applies per edge):
  1. rst: all zero.
  2. flush: bubble. Even if hold=1, flush wins.
  3. hold: all ex_* keep their values.
  4. load_use: bubble. The ID instruction stays upstream and is re-presented next cycle.
  5. otherwise capture: ex_valid=id_valid, ex_op1/ex_op2=forwarded operands, all other fields copied.
- Bubble: every ex_* output = 0, so ex_valid=0, ex_we=0, ex_is_load=0.
- Latency: 1 cycle from ID presentation to ex_* outputs. Load-use costs exactly 1 bubble cycle. The following capture takes the loaded value via the MEM/WB path.
- Capture with id_valid=0 copies 0 into ex_valid. ex_we/ex_is_load are gated to 0 when id_valid=0.
- Held operands stay stable regardless of later forwarding-source changes; forwarding applies only at capture.
- No arithmetic; all fields are pure width-preserving copies.

Test Plan:
1. rst=1 for one edge with nonzero inputs → all ex_* = 0 and id_stall=0 in the next cycle.
2. Capture with raddr1=3, exmem(we=1,waddr=3,wdata=0xAAAA0001), memwb(we=1,waddr=3,wdata=0xBBBB0002), id_rdata1=0x11 → ex_op1=0xAAAA0001. Repeat with exmem_we=0 → 0xBBBB0002. Repeat with raddr1=0 and both sources pointing at 0 → ex_op1=id_rdata1.
3. Load x5 captured into EX, next ID reads x5 (rs2_used=1) → id_stall=1 for exactly one cycle, then ex_valid=0 for one cycle. The following edge captures with memwb(waddr=5,wdata=0x1234) → ex_op2=0x1234.
4. Same as 3 but rs2_used=0 (immediate form), or load dest = x0 → id_stall=0 and no bubble.
5. hold=1 for 3 cycles with changing ID inputs → ex_* unchanged and id_stall=1. Assert flush in the 2nd hold cycle → ex_valid=0 and ex_we=0 at that edge, and id_stall=0 in that cycle.
6. flush=1 together with a load-use condition → bubble captured, id_stall=0, and the ID instruction is not re-presented (upstream discards it).
